// File: rtl/ifetch_pkg.sv
// Types and constants shared between the instruction fetcher and the
// decoded-instruction FIFO.
package ifetch_pkg;

    localparam int INSN_WIDTH = 24;

    typedef logic [INSN_WIDTH-1:0] insn_t;

    // Request-PC pseudo-instruction the fetcher injects into the stream.
    localparam insn_t DI_REQUESTPC = 24'h178000;

endpackage

// File: rtl/insn_fifo_ram.sv
// Storage array for insn_fifo: one synchronous write port and one
// asynchronous read port, so the head word is visible without a read cycle.
module insn_fifo_ram #(
    parameter int INSN_WIDTH = ifetch_pkg::INSN_WIDTH,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [INSN_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [INSN_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [INSN_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; occupancy lives in the pointers and count,
    // so stale words are never observable and the array can map to LUT-RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/insn_fifo.sv
// Decoded-instruction FIFO between the fetcher and the execution stage.
// Optional INSN_FIFO_BYPASS_EN: an empty FIFO forwards di to do_data in the same cycle.
module insn_fifo #(
    parameter int INSN_WIDTH = ifetch_pkg::INSN_WIDTH,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSN_WIDTH-1:0] di,
    input  logic                  shift,
    output logic                  full,
    output logic                  empty,
    output logic [INSN_WIDTH-1:0] do_data,
    output logic                  do_valid,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic [INSN_WIDTH-1:0] ram_rdata;
    logic                  bypass;
    logic                  pop_acc;
    logic                  wr_acc;
    logic                  ram_we;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef INSN_FIFO_BYPASS_EN
    // Flush wins over the bypass just as it wins over a normal write.
    assign bypass  = empty && shift && !flush;
    assign do_data = empty ? di : ram_rdata;
`else
    assign bypass  = 1'b0;
    assign do_data = ram_rdata;
`endif

    assign do_valid = !empty || bypass;
    assign pop_acc  = pop && do_valid;
    assign wr_acc   = shift && (!full || pop_acc);
    // A bypassed word that is popped immediately never needs to be stored.
    assign ram_we   = wr_acc && !flush && !(bypass && pop);

    insn_fifo_ram #(
        .INSN_WIDTH(INSN_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr_q),
        .wdata(di),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    // NOTE: every next-state signal gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (shift && !wr_acc) begin
                overflow_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_insn_fifo.sv
// Scoreboard bench for insn_fifo: directed fill/drain/overflow/flush/bypass
// vectors followed by a long random shift/pop/flush stream.
module tb_insn_fifo;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        shift;
    logic        pop;
    logic        flush;
    insn_t       di;
    insn_t       do_data;
    logic        full;
    logic        empty;
    logic        do_valid;
    logic        overflow;
    logic [2:0]  count;

    int    n_cmp = 0;
    int    n_err = 0;
    insn_t exp_q[$];
    int    mcount = 0;
    bit    movf   = 1'b0;
    insn_t mon_exp;

    insn_fifo #(.INSN_WIDTH(24), .DEPTH_LOG2(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .di      (di),
        .shift   (shift),
        .full    (full),
        .empty   (empty),
        .do_data (do_data),
        .do_valid(do_valid),
        .pop     (pop),
        .flush   (flush),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " count"}, 32'(count), 32'(mcount));
        check({tag, " full"}, 32'(full), 32'(mcount == 4));
        check({tag, " empty"}, 32'(empty), 32'(mcount == 0));
        check({tag, " overflow"}, 32'(overflow), 32'(movf));
`ifndef INSN_FIFO_BYPASS_EN
        check({tag, " do_valid"}, 32'(do_valid), 32'(mcount != 0));
`endif
    endtask

    // Drive one cycle, advance the reference model, then check after the edge.
    task automatic step(input bit s, input bit p, input bit f, input insn_t d, input string tag);
        bit mvalid;
        bit pacc;
        bit wacc;
        shift = s;
        pop   = p;
        flush = f;
        di    = d;
        if (f) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            mvalid = (mcount != 0);
`ifdef INSN_FIFO_BYPASS_EN
            mvalid = mvalid || s;
`endif
            pacc = p && mvalid;
            wacc = s && ((mcount < 4) || pacc);
            if (s && !wacc) movf = 1'b1;
            if (wacc) exp_q.push_back(d);
            mcount = mcount + int'(wacc) - int'(pacc);
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        shift = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        di    = '0;
        repeat (2) @(posedge clk);
        #1;
        mcount = 0;
        movf   = 1'b0;
        exp_q.delete();
        check_state("reset");
        check("reset do_valid", 32'(do_valid), 32'd0);
        reset = 1'b0;
    endtask

    // Monitor: every accepted pop must return the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && pop && do_valid && !flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_data: got %h expected nothing (queue empty) at %0t", do_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pop_data", 32'(do_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Fill with 1..4, drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, insn_t'(i), "fill");
        check("fill4 full", 32'(full), 32'd1);
        check("fill4 count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");
        check("drain empty", 32'(empty), 32'd1);

        // Full with simultaneous pop: head consumed, new word stored last.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, insn_t'(i), "fill2");
        step(1'b1, 1'b1, 1'b0, 24'hABCDEF, "shift_pop_full");
        check("shift_pop_full count", 32'(count), 32'd4);
        check("shift_pop_full overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, "drain2");

        // Full without pop: word dropped, overflow sticky.
        for (int i = 5; i <= 8; i++) step(1'b1, 1'b0, 1'b0, insn_t'(i), "fill3");
        step(1'b1, 1'b0, 1'b0, 24'h123456, "overflow");
        check("overflow flag", 32'(overflow), 32'd1);
        check("overflow count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, "drain3");

        // Flush beats shift and pop; overflow survives the flush.
        for (int i = 9; i <= 11; i++) step(1'b1, 1'b0, 1'b0, insn_t'(i), "fill4");
        step(1'b1, 1'b1, 1'b1, 24'h0000CC, "flush");
        check("flush count", 32'(count), 32'd0);
        check("flush empty", 32'(empty), 32'd1);
        check("flush do_valid", 32'(do_valid), 32'd0);
        check("flush keeps overflow", 32'(overflow), 32'd1);

        // Request-PC word into an empty FIFO with pop high.
        do_reset();
        shift = 1'b1;
        pop   = 1'b1;
        flush = 1'b0;
        di    = DI_REQUESTPC;
        #1;
`ifdef INSN_FIFO_BYPASS_EN
        check("bypass do_valid", 32'(do_valid), 32'd1);
        check("bypass do_data", 32'(do_data), 32'h178000);
`else
        check("nobypass do_valid", 32'(do_valid), 32'd0);
`endif
        step(1'b1, 1'b1, 1'b0, DI_REQUESTPC, "reqpc");
`ifdef INSN_FIFO_BYPASS_EN
        check("bypass count", 32'(count), 32'd0);
`else
        check("nobypass count", 32'(count), 32'd1);
        check("nobypass late valid", 32'(do_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, '0, "reqpc_pop");
`endif

        // Random stream against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 2), insn_t'($urandom()), "rand");
        end

        step(1'b0, 1'b0, 1'b0, '0, "idle");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
